bram_disp_map: RTL and testbench
================================

// Module: bram_disp_map
// PURPOSE
//  Block-matching disparity engine on a dual-port BRAM band buffer. A host streams a band of
//  stereo rows (left+right pixel packed per word) over port A, then pulses go. The engine
//  computes a SAD-based disparity for every column of the band's centre row, streams the
//  results out, and raises done. It sits between the pixel DMA and the disparity writer.
// PARAMETERS
//  ROW_W     640  pixels per row (words per row)
//  MAX_WIN   7    max window size; buffer depth = ROW_W*MAX_WIN words
//  MAX_DISP  16   disparities searched, d = 0..MAX_DISP-1
//  PIX_W     8    pixel width
// PORTS
//  clka       in   1   clock, load port and engine
//  reset      in   1   reset, synchronous, active-high; clock clka
//  ena        in   1   port A enable; high = load phase
//  wea        in   4   port A byte write enables
//  addra      in   32  port A word address
//  dina       in   32  [7:0] left pixel, [15:8] right pixel, [31:16] stored, unused
//  clkb       in   1   internal second read port clock; must be the same clock as clka
//  enb        in   1   engine enable; engine stalls (holds all state) while low
//  dinb       in   32  reserved, ignored
//  go         in   1   start request (rising edge)
//  window     in   3   window size request
//  done       out  1   band complete
//  disp_valid out  1   one-cycle strobe per result
//  disp_col   out  10  column index of result
//  disp_out   out  5   disparity result
// BEHAVIOUR
//  - Reset: done=0, disp_valid=0, disp_col=0, disp_out=0, FSM=IDLE, go edge detector cleared.
//    Buffer contents are not cleared.
//  - Write: on clka, if ena && addra < ROW_W*MAX_WIN, byte lane k of mem[addra] <= dina lane k
//    where wea[k]=1. Out-of-range addresses are ignored, with no wrap. Row i, column x lives at
//    address i*ROW_W+x.
//  - FSM IDLE->RUN on go rising edge (go=1 now, 0 last cycle) when ena=0. A go edge while
//    ena=1 is ignored. On entry, weff is latched:
//      window<3 -> 3; even -> window-1; else window.
//    half = weff>>1. Rows 0..weff-1 are used.
//  - RUN: columns x = 0..ROW_W-1 in order.
//    - If x<half or x>ROW_W-1-half: disp_out=0.
//    - Else, for each d with x-d-half >= 0:
//        SAD(d) = sum over i<weff, |j|<=half of |L[i][x+j] - R[i][x+j-d]|.
//      SAD accumulator is 16 bits and cannot overflow. disp_out = argmin SAD; ties go to the
//      smaller d.
//    - Two reads per cycle via ports A and B of the same BRAM. Read latency is 1.
//    - Per column: at most MAX_DISP*weff*weff+4 enabled cycles.
//    - disp_valid pulses for exactly one cycle per column, with disp_col=x.
//  - Done: the cycle after the last column's strobe, FSM=DONE and done=1. done stays high
//    while go=1. When go=0 it returns to IDLE (done=0) the next cycle.
//  - Load during RUN (ena=1) is a caller error. Writes are still performed and the results
//    of that band are undefined.
//  - Reset mid-RUN aborts: no further disp_valid, done=0.
//  - enb=0 freezes the FSM, counters and outputs. disp_valid is held 0 while frozen.
// TESTING
//  - Reset 10 cycles -> done=0, disp_valid=0. Then load 4480 words while go=0 ->
//    done stays 0 and no disp_valid.
//  - L=R=pseudo-random texture, window=7, go edge -> 640 strobes with cols 0..639 in order.
//    All disp_out=0. done=1 one cycle after col 639.
//  - R[i][x]=L[i][x+4] (random L), window=3 -> disp_out=4 for cols 5..638.
//    Cols 0 and 639 output 0. done sticky until go falls.
//  - window=2 -> behaves as 3. window=6 -> behaves as 5, so cols 0,1,638,639 give 0.
//  - go edge with ena=1 -> ignored, FSM stays IDLE. enb low for 50 cycles mid-RUN ->
//    result stream identical, delayed by 50 cycles.
//  - Reset asserted mid-RUN -> disp_valid stops next cycle, done=0. A new go edge restarts
//    from col 0.

Source files
------------

// File: rtl/bram_disp_map.sv
// SAD block-matching disparity engine over a dual-port BRAM band buffer.
// Port A loads the band (left/right pixel pairs); both ports read it back during a run.
module bram_disp_map #(
  parameter int unsigned ROW_W    = 640,
  parameter int unsigned MAX_WIN  = 7,
  parameter int unsigned MAX_DISP = 16,
  parameter int unsigned PIX_W    = 8
) (
  input  logic        clka,
  input  logic        reset,
  input  logic        ena,
  input  logic [3:0]  wea,
  input  logic [31:0] addra,
  input  logic [31:0] dina,
  input  logic        clkb,
  input  logic        enb,
  input  logic [31:0] dinb,
  input  logic        go,
  input  logic [2:0]  window,
  output logic        done,
  output logic        disp_valid,
  output logic [9:0]  disp_col,
  output logic [4:0]  disp_out
);

  localparam int unsigned DEPTH = ROW_W * MAX_WIN;
  localparam int unsigned A_W   = $clog2(DEPTH);
  localparam int unsigned D_W   = $clog2(MAX_DISP);
  localparam int unsigned S_W   = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COL   = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [31:0]      r_mem [DEPTH];
  logic [31:0]      r_rd_a, r_rd_b;
  logic [2:0]       r_state, w_next;
  logic             r_go_d;
  logic [2:0]       r_weff, r_i, r_j;
  logic [9:0]       r_x;
  logic [D_W-1:0]   r_d, r_dlim, r_d1, r_best_d;
  logic [A_W-1:0]   r_rbase;
  logic             r_v1, r_first1, r_last1;
  logic [S_W-1:0]   r_sad, r_best_sad;

  logic [1:0]       w_half;
  logic             w_go_edge, w_edge_col, w_last_ij, w_last_issue, w_better;
  logic [2:0]       w_weff_req;
  logic [9:0]       w_span, w_col_l, w_col_r;
  logic [A_W-1:0]   w_addr_l, w_addr_r;
  logic [D_W-1:0]   w_dlim, w_final_d;
  logic [PIX_W-1:0] w_pix_l, w_pix_r, w_absd;
  logic [S_W-1:0]   w_sad;
  logic             w_unused;

  assign w_unused = ^{dinb, r_rd_a[31:PIX_W], r_rd_b[31:2*PIX_W], r_rd_b[PIX_W-1:0]};

  // Even windows shrink to the next odd size, anything below 3 becomes 3
  assign w_weff_req   = (window < 3'd3) ? 3'd3 : (window[0] ? window : window - 3'd1);
  assign w_half       = r_weff[2:1];
  assign w_go_edge    = go & ~r_go_d;
  assign w_edge_col   = (r_x < 10'(w_half)) || (r_x > 10'(ROW_W - 1) - 10'(w_half));
  assign w_span       = r_x - 10'(w_half);
  assign w_dlim       = (w_span > 10'(MAX_DISP - 1)) ? D_W'(MAX_DISP - 1) : D_W'(w_span);
  assign w_last_ij    = (r_i == r_weff - 3'd1) && (r_j == r_weff - 3'd1);
  assign w_last_issue = w_last_ij && (r_d == r_dlim);
  assign w_col_l      = w_span + 10'(r_j);
  assign w_col_r      = w_col_l - 10'(r_d);
  assign w_addr_l     = r_rbase + A_W'(w_col_l);
  assign w_addr_r     = r_rbase + A_W'(w_col_r);

  assign w_pix_l   = r_rd_a[PIX_W-1:0];
  assign w_pix_r   = r_rd_b[2*PIX_W-1:PIX_W];
  assign w_absd    = (w_pix_l > w_pix_r) ? w_pix_l - w_pix_r : w_pix_r - w_pix_l;
  assign w_sad     = r_first1 ? S_W'(w_absd) : r_sad + S_W'(w_absd);
  // Strict compare with ascending d keeps ties on the smaller disparity
  assign w_better  = (r_d1 == '0) || (w_sad < r_best_sad);
  assign w_final_d = (r_v1 && r_last1 && w_better) ? r_d1 : r_best_d;

  always_ff @(posedge clka) begin
    if (ena && addra < 32'(DEPTH)) begin
      for (int k = 0; k < 4; k++) begin
        if (wea[k]) r_mem[A_W'(addra)][8*k +: 8] <= dina[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clka) begin
    if (enb) r_rd_a <= r_mem[w_addr_l];
  end

  always_ff @(posedge clkb) begin
    if (enb) r_rd_b <= r_mem[w_addr_r];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_go_edge && !ena) w_next = S_COL;
      S_COL:   w_next = w_edge_col ? S_EMIT : S_ISSUE;
      S_ISSUE: if (w_last_issue) w_next = S_DRAIN;
      S_DRAIN: w_next = S_EMIT;
      S_EMIT:  w_next = (r_x == 10'(ROW_W - 1)) ? S_DONE : S_COL;
      S_DONE:  if (!go) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (reset)    r_state <= S_IDLE;
    else if (enb) r_state <= w_next;
  end

  // Counters, SAD pipeline and registered outputs; everything holds while enb is low
  always_ff @(posedge clka) begin
    if (reset) begin
      r_go_d     <= 1'b0;
      done       <= 1'b0;
      disp_valid <= 1'b0;
      disp_col   <= '0;
      disp_out   <= '0;
      r_weff     <= 3'd3;
      r_x        <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_d        <= '0;
      r_dlim     <= '0;
      r_rbase    <= '0;
      r_v1       <= 1'b0;
      r_first1   <= 1'b0;
      r_last1    <= 1'b0;
      r_d1       <= '0;
      r_sad      <= '0;
      r_best_sad <= '0;
      r_best_d   <= '0;
    end else if (enb) begin
      r_go_d     <= go;
      disp_valid <= (w_next == S_EMIT);
      done       <= (w_next == S_DONE);
      r_v1       <= (r_state == S_ISSUE);
      r_first1   <= (r_i == '0) && (r_j == '0);
      r_last1    <= w_last_ij;
      r_d1       <= r_d;
      if (r_v1) r_sad <= w_sad;
      if (r_v1 && r_last1 && w_better) begin
        r_best_sad <= w_sad;
        r_best_d   <= r_d1;
      end
      if (w_next == S_EMIT) begin
        disp_col <= r_x;
        disp_out <= (r_state == S_COL) ? 5'd0 : 5'(w_final_d);
      end
      case (r_state)
        S_IDLE: begin
          if (w_next == S_COL) begin
            r_weff <= w_weff_req;
            r_x    <= '0;
          end
        end
        S_COL: begin
          r_d     <= '0;
          r_i     <= '0;
          r_j     <= '0;
          r_rbase <= '0;
          r_dlim  <= w_dlim;
        end
        S_ISSUE: begin
          if (r_j == r_weff - 3'd1) begin
            r_j <= '0;
            if (r_i == r_weff - 3'd1) begin
              r_i     <= '0;
              r_rbase <= '0;
              r_d     <= r_d + D_W'(1);
            end else begin
              r_i     <= r_i + 3'd1;
              r_rbase <= r_rbase + A_W'(ROW_W);
            end
          end else begin
            r_j <= r_j + 3'd1;
          end
        end
        S_EMIT:  r_x <= r_x + 10'd1;
        default: ;
      endcase
    end else begin
      disp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bram_disp_map.sv
// Scoreboard bench for bram_disp_map on a reduced band (32 columns, 8 disparities).
// Stimulus pushes expected strobes; a negedge monitor pops and compares them.
module tb_bram_disp_map;

  localparam int unsigned ROW_W    = 32;
  localparam int unsigned MAX_WIN  = 7;
  localparam int unsigned MAX_DISP = 8;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned DEPTH    = ROW_W * MAX_WIN;
  localparam int          TMO      = 20000;

  logic        clka = 1'b0;
  logic        clkb;
  logic        reset, ena, enb, go;
  logic [3:0]  wea;
  logic [31:0] addra, dina, dinb;
  logic [2:0]  window;
  logic        done, disp_valid;
  logic [9:0]  disp_col;
  logic [4:0]  disp_out;

  assign clkb = clka;
  always #5 clka = ~clka;

  bram_disp_map #(.ROW_W(ROW_W), .MAX_WIN(MAX_WIN), .MAX_DISP(MAX_DISP), .PIX_W(PIX_W)) dut (
    .clka(clka), .reset(reset), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .clkb(clkb), .enb(enb), .dinb(dinb), .go(go), .window(window),
    .done(done), .disp_valid(disp_valid), .disp_col(disp_col), .disp_out(disp_out)
  );

  typedef struct packed {
    logic [9:0] col;
    logic [4:0] disp;
    logic       chk;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_cyc = 0;
  int         lat_ref, lat_frz, lat_tmp;
  logic [7:0] lpix [DEPTH];
  logic [7:0] rpix [DEPTH];

  always @(posedge clka) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard
  always @(negedge clka) begin
    if (disp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got col %0d expected no strobe (cycle %0d)", disp_col, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("disp_col", 32'(disp_col), 32'(mon_e.col));
        if (mon_e.chk) chk("disp_out", 32'(disp_out), 32'(mon_e.disp));
        if (disp_col == 10'(ROW_W - 1)) last_cyc = cyc;
      end
    end
  end

  // mode 0: L=R, all zero; mode 1: R shifted by 4, h = half window
  task automatic push_exp(input int mode, input int h);
    exp_t e;
    for (int x = 0; x < ROW_W; x++) begin
      e.col  = 10'(x);
      e.disp = 5'd0;
      e.chk  = 1'b1;
      if (mode == 1 && x >= h && x <= ROW_W - 1 - h) begin
        if (x >= 4 + h) e.disp = 5'd4;
        else            e.chk  = 1'b0;
      end
      sbq.push_back(e);
    end
  endtask

  task automatic write_word(input int a, input logic [3:0] we, input logic [31:0] d);
    @(negedge clka);
    ena   = 1'b1;
    wea   = we;
    addra = 32'(a);
    dina  = d;
  endtask

  task automatic load_band();
    for (int a = 0; a < DEPTH; a++) write_word(a, 4'hF, {16'hC3A5, rpix[a], lpix[a]});
    @(negedge clka);
    ena = 1'b0;
    wea = 4'h0;
  endtask

  task automatic run(input logic [2:0] w, input int freeze_at, output int lat);
    bit seen;
    int n;
    int go_cyc;
    seen   = 1'b0;
    n      = 0;
    window = w;
    @(negedge clka);
    go     = 1'b1;
    go_cyc = cyc;
    while (!seen && n < TMO) begin
      @(negedge clka);
      n++;
      if (freeze_at != 0 && n == freeze_at) begin
        enb = 1'b0;
        for (int k = 0; k < 50; k++) begin
          @(negedge clka);
          if (k > 0) chk("frozen_valid", 32'(disp_valid), 32'd0);
        end
        enb = 1'b1;
      end
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", TMO);
    end else begin
      chk("done_after_last", 32'(cyc), 32'(last_cyc + 1));
    end
    chk("all_strobes", 32'(sbq.size()), 32'd0);
    sbq.delete();
    lat = last_cyc - go_cyc;
    for (int k = 0; k < 3; k++) begin
      @(negedge clka);
      chk("done_sticky", 32'(done), 32'd1);
    end
    go = 1'b0;
    @(negedge clka);
    @(negedge clka);
    chk("done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    ena    = 1'b0;
    enb    = 1'b1;
    go     = 1'b0;
    wea    = 4'h0;
    addra  = '0;
    dina   = '0;
    dinb   = 32'hDEAD_BEEF;
    window = 3'd7;

    repeat (10) @(negedge clka);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(disp_valid), 32'd0);
    chk("rst_col", 32'(disp_col), 32'd0);
    chk("rst_disp", 32'(disp_out), 32'd0);
    reset = 1'b0;

    // Identical texture on both eyes
    for (int a = 0; a < DEPTH; a++) begin
      lpix[a] = 8'($urandom);
      rpix[a] = lpix[a];
    end
    load_band();
    repeat (5) @(negedge clka);
    chk("load_no_done", 32'(done), 32'd0);
    push_exp(0, 3);
    run(3'd7, 0, lat_tmp);

    // Right row is left row shifted by four pixels
    for (int i = 0; i < MAX_WIN; i++) begin
      for (int x = 0; x < ROW_W; x++) begin
        rpix[i*ROW_W + x] = (x + 4 < ROW_W) ? lpix[i*ROW_W + x + 4] : 8'($urandom);
      end
    end
    load_band();
    // Upper-lane-only writes must leave the pixels intact
    for (int a = 0; a < 3*ROW_W; a++) write_word(a, 4'b1100, 32'h5A5A_0000);
    // Out-of-range writes must not wrap onto rows 0..2
    for (int a = 0; a < 3*ROW_W; a++) write_word(256 + a, 4'hF, 32'h0000_0000);
    @(negedge clka);
    ena = 1'b0;
    wea = 4'h0;

    // go edge during load is ignored
    @(negedge clka);
    ena = 1'b1;
    go  = 1'b1;
    repeat (2) @(negedge clka);
    ena = 1'b0;
    repeat (5) @(negedge clka);
    go = 1'b0;
    repeat (10) @(negedge clka);
    chk("ena_go_ignored", 32'(done), 32'd0);

    push_exp(1, 1);
    run(3'd3, 0, lat_ref);
    chk("col_budget", 32'(lat_ref <= ROW_W * (MAX_DISP*9 + 4) + 2), 32'd1);

    push_exp(1, 1);
    run(3'd2, 0, lat_tmp);
    chk("win2_as_3", 32'(lat_tmp), 32'(lat_ref));

    push_exp(1, 2);
    run(3'd6, 0, lat_tmp);

    push_exp(1, 1);
    run(3'd3, 400, lat_frz);
    chk("freeze_delay", 32'(lat_frz), 32'(lat_ref + 50));

    // Abort mid-run, then restart from column 0
    push_exp(1, 1);
    window = 3'd3;
    @(negedge clka);
    go = 1'b1;
    repeat (300) @(negedge clka);
    reset = 1'b1;
    @(negedge clka);
    chk("abort_valid", 32'(disp_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    sbq.delete();
    go = 1'b0;
    repeat (3) @(negedge clka);
    reset = 1'b0;
    repeat (20) @(negedge clka);
    chk("abort_idle", 32'(done), 32'd0);
    push_exp(1, 1);
    run(3'd3, 0, lat_tmp);
    chk("restart_latency", 32'(lat_tmp), 32'(lat_ref));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
